multicycle_controller: RTL and testbench

//  Main control FSM for the multi-cycle RV32I core. Sequences fetch/decode/execute over a shared
//  ALU, single unified memory and the immediate extender. Drives all datapath enables/selects,

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The controller side is the master; the datapath (or a bench) is the slave.
interface multicycle_controller_if #(
  parameter int INSTRET_W = 32
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 Zero;
  logic                 mem_ready;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [2:0]           ALUControl;
  logic [2:0]           ImmSrc;
  logic                 trap;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, trap, instret
  );

  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, trap, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute,
// drives datapath enables/selects, counts retired instructions, traps on illegal opcodes.
module multicycle_controller #(
  parameter int INSTRET_W       = 32,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t               state_r;
  state_t               next_state_s;
  logic [INSTRET_W-1:0] instret_r;
  logic                 adr_src_s;
  logic                 mem_write_s;
  logic                 ir_write_s;
  logic                 reg_write_s;
  logic [1:0]           result_src_s;
  logic [1:0]           alu_src_a_s;
  logic [1:0]           alu_src_b_s;
  logic [1:0]           alu_op_s;
  logic                 branch_s;
  logic                 pc_update_s;
  logic                 trap_s;
  logic [2:0]           alu_control_s;
  logic [2:0]           imm_src_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retired-instruction counter: one count per return to FETCH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret_r <= {INSTRET_W{1'b0}};
    end else if ((next_state_s == S_FETCH) && (state_r != S_FETCH)) begin
      instret_r <= instret_r + INSTRET_W'(1);
    end else begin
      instret_r <= instret_r;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    next_state_s = state_r;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    branch_s     = 1'b0;
    pc_update_s  = 1'b0;
    trap_s       = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        // FETCH is also the reset state, so its strobes must stay quiet while reset is held
        ir_write_s   = bus.mem_ready & reset_n;
        pc_update_s  = bus.mem_ready & reset_n;
        if (bus.mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_R:         next_state_s = S_EXECUTER;
          OP_I:         next_state_s = S_EXECUTEI;
          OP_BEQ:       next_state_s = S_BEQ;
          OP_JAL:       next_state_s = S_JAL;
          OP_LUI:       next_state_s = S_LUI;
          default: begin
            if (TRAP_ON_ILLEGAL != 0) begin
              next_state_s = S_TRAP;
            end else begin
              next_state_s = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (bus.op == OP_LW) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_EXECUTER: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = 2'b10;
        next_state_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b01;
        alu_op_s     = 2'b10;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = 2'b01;
        branch_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_s  = 2'b01;
        alu_src_b_s  = 2'b10;
        pc_update_s  = 1'b1;
        next_state_s = S_ALUWB;
      end
      S_LUI: begin
        result_src_s = 2'b11;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_TRAP: begin
        trap_s       = 1'b1;
        next_state_s = S_TRAP;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // ALU control from ALUOp, funct3 and the R-type subtract bit
  always_comb begin
    alu_control_s = 3'b000;
    case (alu_op_s)
      2'b00: alu_control_s = 3'b000;
      2'b01: alu_control_s = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000: begin
            if (bus.op[5] && bus.funct7b5) begin
              alu_control_s = 3'b001;
            end else begin
              alu_control_s = 3'b000;
            end
          end
          3'b010:  alu_control_s = 3'b101;
          3'b110:  alu_control_s = 3'b011;
          3'b111:  alu_control_s = 3'b010;
          default: alu_control_s = 3'b000;
        endcase
      end
      default: alu_control_s = 3'b000;
    endcase
  end

  // Immediate format select, purely from the opcode
  always_comb begin
    imm_src_s = 3'b000;
    case (bus.op)
      OP_LW, OP_I: imm_src_s = 3'b000;
      OP_SW:       imm_src_s = 3'b001;
      OP_BEQ:      imm_src_s = 3'b010;
      OP_JAL:      imm_src_s = 3'b011;
      OP_LUI:      imm_src_s = 3'b100;
      default:     imm_src_s = 3'b000;
    endcase
  end

  assign bus.PCWrite    = (branch_s & bus.Zero) | pc_update_s;
  assign bus.AdrSrc     = adr_src_s;
  assign bus.MemWrite   = mem_write_s;
  assign bus.IRWrite    = ir_write_s;
  assign bus.RegWrite   = reg_write_s;
  assign bus.ResultSrc  = result_src_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ALUControl = alu_control_s;
  assign bus.ImmSrc     = imm_src_s;
  assign bus.trap       = trap_s;
  assign bus.instret    = instret_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: instruction-level phase plans
// produce per-cycle expected outputs that a negedge monitor compares against the DUT.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MW = 5,
                 PH_ER = 6, PH_EI = 7, PH_AW = 8, PH_BEQ = 9, PH_JAL = 10,
                 PH_LUI = 11, PH_TRAP = 12;

  typedef struct {
    logic [17:0] vec;
    logic [31:0] ir;
    int          mode2;
    logic        mr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multicycle_controller_if #(.INSTRET_W(32)) bus ();
  multicycle_controller_if #(.INSTRET_W(2))  bus2 ();

  assign bus2.op        = bus.op;
  assign bus2.funct3    = bus.funct3;
  assign bus2.funct7b5  = bus.funct7b5;
  assign bus2.Zero      = bus.Zero;
  assign bus2.mem_ready = bus.mem_ready;

  multicycle_controller #(.INSTRET_W(32), .TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master));
  multicycle_controller #(.INSTRET_W(2), .TRAP_ON_ILLEGAL(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.master));

  wire [17:0] act1 = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                      bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
                      bus.trap};
  wire [17:0] act2 = {bus2.PCWrite, bus2.AdrSrc, bus2.MemWrite, bus2.IRWrite, bus2.RegWrite,
                      bus2.ResultSrc, bus2.ALUSrcA, bus2.ALUSrcB, bus2.ALUControl, bus2.ImmSrc,
                      bus2.trap};

  exp_t exp_q[$];
  int   ph_q[$];
  logic mr_q[$];
  int   checks = 0;
  int   failures = 0;
  int   retired = 0;
  logic [6:0] legal_ops [7];

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act_v, exp_v);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BEQ) || (o == OP_JAL) || (o == OP_LUI);
  endfunction

  // Expected output word for one cycle spent in a given phase of an instruction
  function automatic logic [17:0] expect_vec(input int ph, input logic [6:0] o,
      input logic [2:0] f3, input logic f7, input logic z, input logic mr);
    logic pcw, adr, mw, irw, rw, trp;
    logic [1:0] rs, a, b;
    logic [2:0] alu, imm;
    pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; trp = 1'b0;
    rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
    if (o == OP_SW) imm = 3'b001;
    else if (o == OP_BEQ) imm = 3'b010;
    else if (o == OP_JAL) imm = 3'b011;
    else if (o == OP_LUI) imm = 3'b100;
    else imm = 3'b000;
    case (ph)
      PH_F:    begin b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      PH_D:    begin a = 2'b01; b = 2'b01; end
      PH_MA:   begin a = 2'b10; b = 2'b01; end
      PH_MR:   adr = 1'b1;
      PH_MWB:  begin rs = 2'b01; rw = 1'b1; end
      PH_MW:   begin adr = 1'b1; mw = 1'b1; end
      PH_ER:   a = 2'b10;
      PH_EI:   begin a = 2'b10; b = 2'b01; end
      PH_AW:   rw = 1'b1;
      PH_BEQ:  begin a = 2'b10; pcw = z; alu = 3'b001; end
      PH_JAL:  begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      PH_LUI:  begin rs = 2'b11; rw = 1'b1; end
      PH_TRAP: trp = 1'b1;
      default: trp = 1'b0;
    endcase
    if (ph == PH_ER || ph == PH_EI) begin
      case (f3)
        3'b000:  alu = (ph == PH_ER && f7) ? 3'b001 : 3'b000;
        3'b010:  alu = 3'b101;
        3'b110:  alu = 3'b011;
        3'b111:  alu = 3'b010;
        default: alu = 3'b000;
      endcase
    end
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, trp};
  endfunction

  task automatic add_ph(input int ph, input int stalls);
    if (stalls < 0) begin
      ph_q.push_back(ph);
      mr_q.push_back(1'($urandom));
    end else begin
      for (int i = 0; i < stalls; i++) begin
        ph_q.push_back(ph);
        mr_q.push_back(1'b0);
      end
      ph_q.push_back(ph);
      mr_q.push_back(1'b1);
    end
  endtask

  // Drive the planned phases one cycle each and queue the expected outputs
  task automatic run_phases(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    exp_t e;
    bit first_trap;
    first_trap = 1'b1;
    for (int i = 0; i < ph_q.size(); i++) begin
      bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
      bus.Zero = 1'($urandom); bus.mem_ready = mr_q[i];
      e.vec = expect_vec(ph_q[i], o, f3, f7, bus.Zero, mr_q[i]);
      e.ir  = 32'(retired);
      e.mr  = mr_q[i];
      if (ph_q[i] == PH_TRAP) begin
        e.mode2 = first_trap ? 2 : 0;
        first_trap = 1'b0;
      end else begin
        e.mode2 = 1;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int stall);
    int st;
    st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    ph_q.delete();
    mr_q.delete();
    add_ph(PH_F, int'($urandom_range(0, 2)));
    add_ph(PH_D, -1);
    case (o)
      OP_LW:   begin add_ph(PH_MA, -1); add_ph(PH_MR, st); add_ph(PH_MWB, -1); end
      OP_SW:   begin add_ph(PH_MA, -1); add_ph(PH_MW, st); end
      OP_R:    begin add_ph(PH_ER, -1); add_ph(PH_AW, -1); end
      OP_I:    begin add_ph(PH_EI, -1); add_ph(PH_AW, -1); end
      OP_BEQ:  add_ph(PH_BEQ, -1);
      OP_JAL:  begin add_ph(PH_JAL, -1); add_ph(PH_AW, -1); end
      OP_LUI:  add_ph(PH_LUI, -1);
      default: begin add_ph(PH_TRAP, -1); add_ph(PH_TRAP, -1); add_ph(PH_TRAP, -1); end
    endcase
    run_phases(o, f3, f7);
    if (is_legal(o)) retired++;
  endtask

  task automatic do_reset();
    bus.mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("reset_trap", 32'(bus.trap), 32'd0);
    check("reset_instret", bus.instret, 32'd0);
    check("reset_irwrite", 32'(bus.IRWrite), 32'd0);
    check("reset_pcwrite", 32'(bus.PCWrite), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    retired = 0;
  endtask

  // Store stalled in MEMWRITE, then reset lands in the middle of the write
  task automatic reset_mid_sw();
    ph_q.delete();
    mr_q.delete();
    add_ph(PH_F, int'($urandom_range(0, 2)));
    add_ph(PH_D, -1);
    add_ph(PH_MA, -1);
    run_phases(OP_SW, 3'b010, 1'b0);
    bus.mem_ready = 1'b0;
    #1;
    check("memwrite_before_reset", 32'(bus.MemWrite), 32'd1);
    check("adrsrc_before_reset", 32'(bus.AdrSrc), 32'd1);
    bus.mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("memwrite_in_reset", 32'(bus.MemWrite), 32'd0);
    check("adrsrc_in_reset", 32'(bus.AdrSrc), 32'd0);
    check("irwrite_in_reset", 32'(bus.IRWrite), 32'd0);
    check("instret_in_reset", bus.instret, 32'd0);
    check("instret2_in_reset", 32'(bus2.instret), 32'd0);
    @(posedge clk);
    #1;
    check("alusrcb_after_reset_edge", 32'(bus.ALUSrcB), 32'd2);
    reset_n = 1'b1;
    retired = 0;
  endtask

  // Scoreboard monitor: one queued expectation per DUT cycle
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] nxt;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", 32'(act1), 32'(e.vec));
      check("instret", bus.instret, e.ir);
      if (e.mode2 == 1) begin
        check("outputs_nop_variant", 32'(act2), 32'(e.vec));
        check("instret_wrap2", 32'(bus2.instret), 32'(e.ir[1:0]));
      end else if (e.mode2 == 2) begin
        nxt = e.ir + 32'd1;
        check("nop_retire_wrap2", 32'(bus2.instret), 32'(nxt[1:0]));
        check("nop_back_to_fetch", 32'(bus2.IRWrite), 32'(e.mr));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] o;
    int n;
    legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI};
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    run_instr(OP_R,   3'b000, 1'b0, -1);
    run_instr(OP_R,   3'b000, 1'b1, -1);
    run_instr(OP_I,   3'b000, 1'b1, -1);
    run_instr(OP_SW,  3'b010, 1'b0, 3);
    run_instr(OP_BEQ, 3'b000, 1'b0, -1);
    run_instr(OP_BEQ, 3'b000, 1'b1, -1);
    run_instr(OP_JAL, 3'b000, 1'b0, -1);
    run_instr(OP_LUI, 3'b000, 1'b0, -1);
    run_instr(OP_LW,  3'b010, 1'b0, 2);
    run_instr(OP_R,   3'b010, 1'b0, -1);
    run_instr(OP_R,   3'b110, 1'b1, -1);
    run_instr(OP_I,   3'b111, 1'b0, -1);
    run_instr(OP_R,   3'b001, 1'b1, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, -1);
    do_reset();
    for (int s = 0; s < 12; s++) begin
      n = int'($urandom_range(6, 20));
      for (int k = 0; k < n; k++) begin
        o = legal_ops[$urandom_range(0, 6)];
        run_instr(o, 3'($urandom), 1'($urandom), -1);
      end
      if ((s % 2) == 0) begin
        do begin
          o = 7'($urandom);
        end while (is_legal(o));
        run_instr(o, 3'($urandom), 1'($urandom), -1);
        do_reset();
      end else begin
        reset_mid_sw();
      end
    end
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
